image_src_gen: RTL

Streaming frame source that drives the image-pipe input interface (data/valid/end, with busy backpressure). It is the transmitting end of the same stream protocol that the image pipe consumes. It generates one programmable-size test frame per start pulse, honours downstream busy, and signals frame end. It sits in the testbench/BIST path ahead of the image pipe; its `cfg_*` inputs are driven from the register block.

---
 rtl/image_src_gen_if.sv | 23 ++
 rtl/image_src_gen.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/image_src_gen_if.sv
// Pixel stream between a frame source and the image pipe: data/valid/end forward, busy back.
interface image_src_gen_if #(
   parameter int DW = 32
);
   logic [DW-1:0] src_data_out;
   logic          src_valid_out;
   logic          src_end_out;
   logic          src_busy_in;

   modport master (
      output src_data_out,
      output src_valid_out,
      output src_end_out,
      input  src_busy_in
   );

   modport slave (
      input  src_data_out,
      input  src_valid_out,
      input  src_end_out,
      output src_busy_in
   );
endinterface

// File: rtl/image_src_gen.sv
// Test-frame source: one raster frame per start, first pixel one cycle after start,
// outputs frozen while busy is high, programmable inter-pixel gap, end flag held until busy drops.
module image_src_gen #(
   parameter int DW = 32
) (
   input  logic        clk,
   input  logic        s_rst,
   input  logic        start,
   input  logic [12:0] cfg_width,
   input  logic [15:0] cfg_height,
   input  logic [1:0]  cfg_pattern,
   input  logic [3:0]  cfg_gap,
   output logic        src_active,
   image_src_gen_if.master src
);

   typedef enum logic [1:0] {IDLE, RUN, ENDF} state_t;

   state_t      state_q, state_d;
   logic [12:0] w_q, w_d;
   logic [15:0] h_q, h_d;
   logic [1:0]  pat_q, pat_d;
   logic [3:0]  gap_q, gap_d;
   logic [12:0] x_q, x_d;
   logic [15:0] y_q, y_d;
   logic [28:0] idx_q, idx_d;
   logic [3:0]  gcnt_q, gcnt_d;
   logic        vld_q, vld_d;
   logic        end_q, end_d;
   logic        last_px;
   logic [28:0] pv;
   logic [DW-1:0] data;

   assign last_px = (x_q == w_q - 13'd1) && (y_q == h_q - 16'd1);

   always_comb begin
      state_d = state_q;
      w_d     = w_q;
      h_d     = h_q;
      pat_d   = pat_q;
      gap_d   = gap_q;
      x_d     = x_q;
      y_d     = y_q;
      idx_d   = idx_q;
      gcnt_d  = gcnt_q;
      vld_d   = vld_q;
      end_d   = end_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               w_d    = cfg_width;
               h_d    = cfg_height;
               pat_d  = cfg_pattern;
               gap_d  = cfg_gap;
               x_d    = '0;
               y_d    = '0;
               idx_d  = '0;
               gcnt_d = '0;
               if (cfg_width == 13'd0 || cfg_height == 16'd0) begin
                  state_d = ENDF;
                  end_d   = 1'b1;
               end else begin
                  state_d = RUN;
                  vld_d   = 1'b1;
               end
            end
         end
         RUN: begin
            if (vld_q) begin
               if (!src.src_busy_in) begin
                  if (last_px) begin
                     // Counters return to 0 so data reads 0 outside a frame.
                     state_d = ENDF;
                     vld_d   = 1'b0;
                     end_d   = 1'b1;
                     x_d     = '0;
                     y_d     = '0;
                     idx_d   = '0;
                  end else begin
                     idx_d = idx_q + 29'd1;
                     if (x_q == w_q - 13'd1) begin
                        x_d = '0;
                        y_d = y_q + 16'd1;
                     end else begin
                        x_d = x_q + 13'd1;
                     end
                     if (gap_q != 4'd0) begin
                        vld_d  = 1'b0;
                        gcnt_d = gap_q;
                     end
                  end
               end
            end else begin
               // Gap countdown is independent of busy.
               if (gcnt_q <= 4'd1) begin
                  gcnt_d = '0;
                  vld_d  = 1'b1;
               end else begin
                  gcnt_d = gcnt_q - 4'd1;
               end
            end
         end
         ENDF: begin
            if (!src.src_busy_in) begin
               state_d = IDLE;
               end_d   = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (s_rst) begin
         state_q <= IDLE;
         w_q     <= '0;
         h_q     <= '0;
         pat_q   <= '0;
         gap_q   <= '0;
         x_q     <= '0;
         y_q     <= '0;
         idx_q   <= '0;
         gcnt_q  <= '0;
         vld_q   <= 1'b0;
         end_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         w_q     <= w_d;
         h_q     <= h_d;
         pat_q   <= pat_d;
         gap_q   <= gap_d;
         x_q     <= x_d;
         y_q     <= y_d;
         idx_q   <= idx_d;
         gcnt_q  <= gcnt_d;
         vld_q   <= vld_d;
         end_q   <= end_d;
      end
   end

   always_comb begin
      case (pat_q)
         2'd0:    pv = idx_q;
         2'd1:    pv = {16'b0, x_q};
         2'd2:    pv = {13'b0, y_q};
         default: pv = {13'b0, {3'b0, x_q} ^ y_q};
      endcase
   end

   // Truncate or zero-extend the 29-bit pattern to DW.
   always_comb begin
      data = '0;
      for (int i = 0; i < DW && i < 29; i++) data[i] = pv[i];
   end

   assign src.src_data_out  = data;
   assign src.src_valid_out = vld_q;
   assign src.src_end_out   = end_q;
   assign src_active        = (state_q != IDLE);

endmodule
